// File: rtl/result_sender_if.sv
// result_sender_if: result-memory read port (rm_ena/rm_addra/rm_doa) and UART byte handshake (tx_data/tx_valid/tx_ready)
interface result_sender_if #(
  parameter int RES_ADDR_WIDTH = 4,
  parameter int RES_DATA_WIDTH = 16
);
  logic                      rm_ena;
  logic [RES_ADDR_WIDTH-1:0] rm_addra;
  logic [RES_DATA_WIDTH-1:0] rm_doa;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  modport master(output rm_ena, rm_addra, tx_data, tx_valid, input rm_doa, tx_ready);
  modport slave(input rm_ena, rm_addra, tx_data, tx_valid, output rm_doa, tx_ready);
endinterface

// File: rtl/result_sender.sv
// result_sender: reads n scores and streams FF 04 n {hi,lo}*n argmax FF over a valid/ready byte port; busy/done/StateLED status
module result_sender #(
  parameter int RES_ADDR_WIDTH = 4,
  parameter int RES_DATA_WIDTH = 16
) (
  input  logic                  clk_11MHz,
  input  logic                  resetn,
  input  logic                  start_send,
  input  logic [7:0]            num_class,
  result_sender_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            StateLED
);
  typedef enum logic [3:0] {IDLE, HDR, TYPE, COUNT, RD_REQ, RD_WAIT, SC_HI, SC_LO, ARGMAX, TRAIL, FIN} state_t;
  localparam logic [8:0] CAP = 9'(2 ** RES_ADDR_WIDTH);
  state_t state_q, state_d;
  logic [8:0] n_q, n_d, k_q, k_d;
  logic [RES_DATA_WIDTH-1:0] score_q, score_d, max_q, max_d;
  logic [RES_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic led_q, led_d;
  logic start, xfer, upd;
  logic [15:0] sc16;
  assign start = state_q == IDLE && start_send;
  assign xfer  = bus.tx_valid && bus.tx_ready;
  assign upd   = state_q == RD_WAIT && (k_q == '0 || $signed(bus.rm_doa) > $signed(max_q));
  assign sc16  = 16'($signed(score_q));
  always_ff @(posedge clk_11MHz or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      score_q <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      score_q <= score_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_send ? HDR : IDLE;
      HDR:     state_d = xfer ? TYPE : HDR;
      TYPE:    state_d = xfer ? COUNT : TYPE;
      COUNT:   state_d = !xfer ? COUNT : n_q != '0 ? RD_REQ : ARGMAX;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = SC_HI;
      SC_HI:   state_d = xfer ? SC_LO : SC_HI;
      SC_LO:   state_d = !xfer ? SC_LO : k_q + 9'd1 < n_q ? RD_REQ : ARGMAX;
      ARGMAX:  state_d = xfer ? TRAIL : ARGMAX;
      TRAIL:   state_d = xfer ? FIN : TRAIL;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    n_d     = start ? ({1'b0, num_class} > CAP ? CAP : {1'b0, num_class}) : n_q;
    k_d     = start ? '0 : state_q == SC_LO && xfer ? k_q + 9'd1 : k_q;
    score_d = state_q == RD_WAIT ? bus.rm_doa : score_q;
    max_d   = start ? '0 : upd ? bus.rm_doa : max_q;
    idx_d   = start ? '0 : upd ? k_q[RES_ADDR_WIDTH-1:0] : idx_q;
    led_d   = start ? 1'b0 : state_q == FIN ? 1'b1 : led_q;
  end
  always_comb begin
    bus.tx_valid = state_q inside {HDR, TYPE, COUNT, SC_HI, SC_LO, ARGMAX, TRAIL};
    bus.tx_data  = state_q inside {HDR, TRAIL} ? 8'hFF :
                   state_q == TYPE   ? 8'h04 :
                   state_q == COUNT  ? n_q[7:0] :
                   state_q == SC_HI  ? sc16[15:8] :
                   state_q == SC_LO  ? sc16[7:0] :
                   state_q == ARGMAX ? 8'(idx_q) : 8'h00;
    bus.rm_ena   = state_q == RD_REQ;
    bus.rm_addra = state_q == RD_REQ ? k_q[RES_ADDR_WIDTH-1:0] : '0;
    busy         = state_q != IDLE && state_q != FIN;
    done         = state_q == FIN;
    StateLED     = {1'b0, led_q || state_q == FIN, state_q inside {RD_REQ, RD_WAIT, SC_HI, SC_LO},
                    state_q != IDLE && state_q != FIN};
  end
endmodule

// File: tb/tb_result_sender.sv
// tb_result_sender: randomized frames checked every cycle against a queue-based frame model
module tb_result_sender;
  localparam int AW = 4;
  localparam int DW = 16;
  typedef logic [7:0] bq_t[$];
  logic clk_11MHz = 1'b0;
  logic resetn = 1'b1;
  logic start_send = 1'b0;
  logic [7:0] num_class = 8'd0;
  logic busy, done;
  logic [3:0] StateLED;
  result_sender_if #(.RES_ADDR_WIDTH(AW), .RES_DATA_WIDTH(DW)) bus();
  result_sender #(.RES_ADDR_WIDTH(AW), .RES_DATA_WIDTH(DW)) dut (
    .clk_11MHz(clk_11MHz), .resetn(resetn), .start_send(start_send), .num_class(num_class),
    .bus(bus.master), .busy(busy), .done(done), .StateLED(StateLED));
  always #5 clk_11MHz = ~clk_11MHz;
  logic [15:0] mem [16];
  int ready_mode = 0;
  int nvec = 0, nmis = 0;
  bq_t exp_q, got;
  bit m_busy = 0, m_done_now = 0, m_led2 = 0, prev_stall = 0;
  logic [7:0] prev_data;
  int sent = 0, rd_idx = 0, m_n = 0, done_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask
  function automatic bq_t frame_of(input int nc);
    bq_t q;
    int n = nc > 16 ? 16 : nc;
    logic signed [15:0] mx = 0;
    int ix = 0;
    q.push_back(8'hFF);
    q.push_back(8'h04);
    q.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      q.push_back(mem[k][15:8]);
      q.push_back(mem[k][7:0]);
      if (k == 0 || $signed(mem[k]) > mx) begin
        mx = mem[k];
        ix = k;
      end
    end
    q.push_back(8'(ix));
    q.push_back(8'hFF);
    return q;
  endfunction
  always @(posedge clk_11MHz) bus.rm_doa <= bus.rm_ena ? mem[bus.rm_addra] : 16'($urandom);
  initial begin
    int stall = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk_11MHz);
      #1;
      if (ready_mode == 0) bus.tx_ready = 1'b1;
      else if (ready_mode == 1) bus.tx_ready = 1'($urandom_range(0, 1));
      else if (stall > 0) begin
        stall--;
        bus.tx_ready = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        stall = 7;
        bus.tx_ready = 1'b0;
      end else bus.tx_ready = 1'b1;
    end
  end
  always @(negedge clk_11MHz) begin
    bit nb, nd;
    if (!resetn) begin
      chk("reset_outputs", {bus.tx_valid, bus.tx_data, bus.rm_ena, bus.rm_addra, busy, done, StateLED}, 32'd0);
      exp_q.delete();
      m_busy = 0; m_done_now = 0; m_led2 = 0; prev_stall = 0; sent = 0; rd_idx = 0; m_n = 0;
    end else begin
      nb = m_busy;
      nd = 0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done_now);
      chk("led0", StateLED[0], m_busy);
      chk("led2", StateLED[2], m_led2 | m_done_now);
      chk("led3", StateLED[3], 0);
      if (!m_busy) chk("led1_idle", StateLED[1], 0);
      chk("tx_valid_when_idle", bus.tx_valid & !m_busy, 0);
      if (prev_stall) begin
        chk("stall_valid", bus.tx_valid, 1);
        chk("stall_data", bus.tx_data, prev_data);
      end
      if (bus.rm_ena) begin
        chk("rm_ena_allowed", m_busy && rd_idx < m_n, 1);
        chk("rm_addra", bus.rm_addra, rd_idx[AW-1:0]);
        rd_idx++;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", bus.tx_data, 32'hFFFF_FFFF);
        else begin
          chk("tx_byte", bus.tx_data, exp_q.pop_front());
          got.push_back(bus.tx_data);
          sent++;
          if (exp_q.size() == 0) begin
            nd = 1;
            nb = 0;
            chk("read_count", rd_idx, m_n);
          end
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
      if (m_done_now) begin
        m_led2 = 1;
        done_cnt++;
      end
      if (start_send && !m_busy && !m_done_now) begin
        exp_q = frame_of(int'(num_class));
        m_n = num_class > 16 ? 16 : int'(num_class);
        nb = 1; m_led2 = 0; sent = 0; rd_idx = 0;
      end
      m_busy = nb;
      m_done_now = nd;
    end
  end
  task automatic tick();
    @(posedge clk_11MHz);
    #1;
  endtask
  task automatic send_frame(input int nc, input int mode, input bit hold_start, input bit poke_mid);
    int d0 = done_cnt;
    ready_mode = mode;
    got.delete();
    num_class = 8'(nc);
    start_send = 1'b1;
    tick();
    if (!hold_start) start_send = 1'b0;
    num_class = 8'($urandom);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      tick();
      if (poke_mid && i == 5) start_send = 1'b1;
      else if (poke_mid && i == 6) start_send = 1'b0;
    end
    start_send = 1'b0;
    if (done_cnt == d0) chk("frame_timeout", 0, 1);
    repeat (2) tick();
  endtask
  task automatic rand_mem();
    for (int i = 0; i < 16; i++)
      mem[i] = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 3)) : 16'($urandom);
  endtask
  initial begin
    logic [7:0] l35 [11] = '{8'hFF, 8'h04, 8'h03, 8'h00, 8'h10, 8'hFF, 8'hF0, 8'h01, 8'h00, 8'h02, 8'hFF};
    logic [7:0] l36 [5] = '{8'hFF, 8'h04, 8'h00, 8'h00, 8'hFF};
    bq_t pin;
    rand_mem();
    #1 resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();
    mem[0] = 16'h0010; mem[1] = 16'hFFF0; mem[2] = 16'h0100;
    pin = frame_of(3);
    chk("model_pin_len", pin.size(), 11);
    chk("model_pin_argmax", pin[9], 8'h02);
    for (int pass = 0; pass < 2; pass++) begin
      send_frame(3, pass == 0 ? 0 : 2, 0, 0);
      chk("frame35_len", got.size(), 11);
      for (int i = 0; i < 11 && i < got.size(); i++) chk("frame35_byte", got[i], l35[i]);
    end
    send_frame(0, 0, 0, 0);
    chk("frame36_len", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("frame36_byte", got[i], l36[i]);
    mem[0] = 16'd5; mem[1] = 16'd5; mem[2] = 16'd3;
    send_frame(3, 1, 0, 0);
    chk("tie_argmax", got.size() > 9 ? got[9] : 8'hEE, 8'h00);
    rand_mem();
    send_frame(40, 1, 0, 1);
    chk("cap_len", got.size(), 37);
    chk("cap_count", got.size() > 2 ? got[2] : 8'hEE, 8'h10);
    rand_mem();
    send_frame(5, 2, 1, 0);
    chk("held_start_idle", busy, 0);
    for (int f = 0; f < 10; f++) begin
      rand_mem();
      send_frame($urandom_range(0, 3) == 0 ? 40 : $urandom_range(0, 20), $urandom_range(0, 2), 0, $urandom_range(0, 1));
    end
    rand_mem();
    ready_mode = 0;
    got.delete();
    num_class = 8'd3;
    start_send = 1'b1;
    tick();
    start_send = 1'b0;
    for (int i = 0; i < 200 && sent < 4; i++) tick();
    chk("reached_sc_lo", sent, 4);
    #1 resetn = 1'b0;
    #1;
    chk("async_reset", {bus.tx_valid, bus.tx_data, bus.rm_ena, bus.rm_addra, busy, done, StateLED}, 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("idle_after_reset", busy, 0);
    send_frame($urandom_range(1, 16), 1, 0, 0);
    chk("restart_first_byte", got.size() > 0 ? got[0] : 8'h00, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected finish", done_cnt);
    $fatal(1);
  end
endmodule

// File: doc/result_sender.md
RESULT_SENDER -- requirements
Module: result_sender

Interface
- REQ-001 The block SHALL have parameter RES_ADDR_WIDTH, default 4: result memory address width.
- REQ-002 The block SHALL have parameter RES_DATA_WIDTH, default 16: result score width, two's complement.
- REQ-003 The block SHALL have port clk_11MHz, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 The block SHALL have port start_send, input, 1 bit: one-cycle request to transmit the result frame.
- REQ-006 The block SHALL have port num_class, input, 8 bits: number of scores to send; sampled when start_send is accepted.
- REQ-007 The block SHALL have port rm_ena, output, 1 bit: result memory read enable.
- REQ-008 The block SHALL have port rm_addra, output, RES_ADDR_WIDTH bits: result memory read address.
- REQ-009 The block SHALL have port rm_doa, input, RES_DATA_WIDTH bits: read data, valid exactly 1 cycle after rm_ena.
- REQ-010 The block SHALL have port tx_data, output, 8 bits: byte to the UART transmitter.
- REQ-011 The block SHALL have port tx_valid, output, 1 bit: tx_data holds a byte to send.
- REQ-012 The block SHALL have port tx_ready, input, 1 bit: the transmitter accepts a byte this cycle.
- REQ-013 The block SHALL have port busy, output, 1 bit: high from start acceptance until the done pulse.
- REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last byte is accepted.
- REQ-015 The block SHALL have port StateLED, output, 4 bits: status display.

Function
- REQ-016 Frame byte order SHALL be: 0xFF, 0x04, n, then for k=0..n-1 score[k][15:8] followed by score[k][7:0], then argmax index, then 0xFF.
- REQ-017 n SHALL be min(num_class, 2^RES_ADDR_WIDTH); the count byte SHALL carry n, not the raw num_class.
- REQ-018 A byte transfer SHALL occur only on a cycle with tx_valid=1 and tx_ready=1.
- REQ-019 While tx_valid=1 and tx_ready=0, tx_valid and tx_data SHALL hold stable; tx_valid SHALL never drop without a transfer.
- REQ-020 FSM states SHALL be IDLE, HDR, TYPE, COUNT, RD_REQ, RD_WAIT, SC_HI, SC_LO, ARGMAX, TRAIL, FIN.
- REQ-021 IDLE->HDR on start_send=1: latch n, clear k, set busy=1; tx_valid=1 with 0xFF on the next cycle.
- REQ-022 HDR->TYPE->COUNT SHALL each advance on transfer; COUNT->RD_REQ if n>0, else ->ARGMAX.
- REQ-023 RD_REQ SHALL assert rm_ena=1 and rm_addra=k for exactly one cycle, then go to RD_WAIT.
- REQ-024 RD_WAIT SHALL capture rm_doa into a score register, update argmax, then go to SC_HI; tx_valid=0 in RD_REQ and RD_WAIT.
- REQ-025 SC_HI->SC_LO on transfer; SC_LO on transfer: k+1, then ->RD_REQ if k+1<n, else ->ARGMAX.
- REQ-026 Argmax SHALL use a signed compare; the index updates only on strictly greater, so ties keep the lower index; the k=0 score always initialises the running max.
- REQ-027 ARGMAX SHALL send the index zero-extended to 8 bits; with n=0 the index SHALL be 0x00.
- REQ-028 ARGMAX->TRAIL->FIN on transfers; FIN SHALL pulse done=1 for one cycle, clear busy, and return to IDLE.
- REQ-029 start_send while busy=1 SHALL be ignored; start_send in the FIN cycle SHALL be ignored.
- REQ-030 The block SHALL never assert rm_ena outside RD_REQ.
- REQ-031 StateLED SHALL show: [0]=busy, [1]=sending scores (RD_REQ..SC_LO), [2]=latched 1 at done and cleared at next start, [3]=0.

Reset
- REQ-032 resetn=0 SHALL, asynchronously, force state to IDLE and drive tx_valid=0, tx_data=0, rm_ena=0, rm_addra=0, busy=0, done=0, StateLED=0.
- REQ-033 resetn=0 SHALL also clear k, n, the score register and the argmax index and max.
- REQ-034 Reset mid-frame SHALL abandon the frame; after release, the block SHALL wait in IDLE for a new start_send.

Verification
- REQ-035 Scores {0x0010, 0xFFF0, 0x0100}, num_class=3, tx_ready=1 -> bytes FF 04 03 00 10 FF F0 01 00 02 FF, then done for one cycle.
- REQ-036 num_class=0 -> FF 04 00 00 FF; rm_ena is never asserted.
- REQ-037 Scores {5,5,3}, num_class=3 -> argmax byte 0x00 (tie keeps the lower index).
- REQ-038 tx_ready toggling pseudo-randomly with 8-cycle stalls -> tx_data/tx_valid stable during stalls; byte stream identical to REQ-035.
- REQ-039 num_class=40 with RES_ADDR_WIDTH=4 -> count byte 0x10, 16 scores sent; start_send pulsed mid-frame -> ignored.
- REQ-040 resetn pulsed low during SC_LO -> all outputs 0 immediately; a new start_send yields a complete frame beginning 0xFF.
